// File: rtl/lfsr_step_ctrl_pkg.sv
// Shared types and constants for the LFSR sequencing controller.
package lfsr_pkg;

  localparam int unsigned LFSR_W     = 8;
  localparam int unsigned STEP_CNT_W = 16;

  // Seed used in place of the all-zero LFSR lockup value
  localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 8'h01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    AUTO  = 2'd2
  } state_e;

endpackage

// File: rtl/lfsr_step_ctrl_if.sv
// Command bus from the sequencing controller to the LFSR register.
interface lfsr_step_ctrl_if;
  import lfsr_pkg::*;

  logic              lfsr_load;
  logic [LFSR_W-1:0] lfsr_seed;
  logic              lfsr_step;

  modport master (output lfsr_load, output lfsr_seed, output lfsr_step);
  modport slave  (input  lfsr_load, input  lfsr_seed, input  lfsr_step);

endinterface

// File: rtl/lfsr_step_ctrl_btn_debounce.sv
// Two-flop synchronizer plus stability-count debouncer with a registered rise pulse.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;

  // Level flips on the DB_CYCLES-th consecutive disagreeing sample
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/lfsr_step_ctrl.sv
// Seed-load / step sequencing FSM with auto-run divider and step counter.
module lfsr_step_ctrl
  import lfsr_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 20000,
  parameter int unsigned DIV_W     = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_step,
  input  logic                  btn_load,
  input  logic                  auto_en,
  input  logic [LFSR_W-1:0]     seed,
  input  logic [DIV_W-1:0]      period,
  lfsr_step_ctrl_if.master      cmd,
  output logic [1:0]            state,
  output logic [STEP_CNT_W-1:0] step_cnt,
  output logic                  seed_err
);

  logic step_ev, load_ev, auto_lvl;
  logic step_lvl_unused, load_lvl_unused, auto_rise_unused;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
    .clk(clk), .rst(rst), .din(btn_step), .level(step_lvl_unused), .rise(step_ev)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_load (
    .clk(clk), .rst(rst), .din(btn_load), .level(load_lvl_unused), .rise(load_ev)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_auto (
    .clk(clk), .rst(rst), .din(auto_en), .level(auto_lvl), .rise(auto_rise_unused)
  );

  state_e                  state_q, state_d;
  logic                    load_q, load_d;
  logic                    step_q, step_d;
  logic [LFSR_W-1:0]       seed_q, seed_d;
  logic                    err_q, err_d;
  logic [STEP_CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [DIV_W-1:0]        per_m1;
  logic                    term;

  // >= rather than == so a period shrinking below the divider wraps at once
  assign per_m1 = (period == '0) ? '0 : period - 1'b1;
  assign term   = (div_q >= per_m1);

  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    step_d  = 1'b0;
    seed_d  = seed_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    if (load_ev) begin
      load_d  = 1'b1;
      cnt_d   = '0;
      div_d   = '0;
      state_d = auto_lvl ? AUTO : READY;
      if (seed == '0) begin
        seed_d = ZERO_SEED_SUB;
        err_d  = 1'b1;
      end else begin
        seed_d = seed;
        err_d  = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: ;
        READY: begin
          if (step_ev) begin
            step_d = 1'b1;
            cnt_d  = cnt_q + 1'b1;
          end
          if (auto_lvl) begin
            state_d = AUTO;
            div_d   = '0;
          end
        end
        AUTO: begin
          if (!auto_lvl) begin
            state_d = READY;
            div_d   = '0;
          end else if (term) begin
            step_d = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            div_d  = '0;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      load_q  <= 1'b0;
      step_q  <= 1'b0;
      seed_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      step_q  <= step_d;
      seed_q  <= seed_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
    end
  end

  assign cmd.lfsr_load = load_q;
  assign cmd.lfsr_step = step_q;
  assign cmd.lfsr_seed = seed_q;
  assign state         = state_q;
  assign step_cnt      = cnt_q;
  assign seed_err      = err_q;

endmodule
